// File: rtl/puf_pkg.sv
// Shared definitions for the ring-oscillator PUF: array geometry, sequencer
// states and the challenge pair-slice helper.
package puf_pkg;

    localparam int N_RO      = 16;
    localparam int SEL_W     = 4;
    localparam int CNT_W     = 12;
    localparam int MAX_PAIRS = 32;
    localparam int CH_MAX_W  = MAX_PAIRS * 2 * SEL_W;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_CLEAR,
        ST_RUN,
        ST_SETTLE,
        ST_SAMPLE,
        ST_DONE
    } seq_state_t;

    // Pair k of a challenge word: {sel2, sel1}, sel1 in the low half.
    function automatic logic [2*SEL_W-1:0] pair_slice(input logic [CH_MAX_W-1:0] ch,
                                                      input int unsigned k);
        return ch[k*2*SEL_W +: 2*SEL_W];
    endfunction

endpackage

// File: rtl/puf_phase_timer.sv
// Loadable down-counter that times each sequencer phase; zero marks the
// last cycle of the phase.
module puf_phase_timer #(
    parameter int W = 12
) (
    input  logic         clk,
    input  logic         srst,
    input  logic         load,
    input  logic [W-1:0] load_value,
    output logic         zero
);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else if (load) begin
            count_reg <= load_value;
        end else if (count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign zero = (count_reg == '0);

endmodule

// File: rtl/puf_challenge_sequencer.sv
// Walks the challenge pairs through clear / window / settle / sample and
// packs the oscillator comparisons into response, tie and saturation words.
module puf_challenge_sequencer
    import puf_pkg::*;
#(
    parameter int RESP_BITS = 8,   // at most MAX_PAIRS
    parameter int WINDOW    = 4095,
    parameter int CLR_CYC   = 2,
    parameter int SETTLE    = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic [RESP_BITS*2*SEL_W-1:0] challenge,
    input  logic [CNT_W-1:0]           cnt1,
    input  logic [CNT_W-1:0]           cnt2,
    output logic [SEL_W-1:0]           ro_select1,
    output logic [SEL_W-1:0]           ro_select2,
    output logic                       ro_enable,
    output logic                       ro_reset,
    output logic                       busy,
    output logic                       done,
    output logic [RESP_BITS-1:0]       response,
    output logic [RESP_BITS-1:0]       tie_mask,
    output logic [RESP_BITS-1:0]       sat_mask
);

    localparam int MAX_LEN = (WINDOW > CLR_CYC) ? ((WINDOW > SETTLE) ? WINDOW : SETTLE)
                                                : ((CLR_CYC > SETTLE) ? CLR_CYC : SETTLE);
    localparam int TW = $clog2(MAX_LEN + 1);
    localparam int KW = (RESP_BITS > 1) ? $clog2(RESP_BITS) : 1;
    localparam logic [KW-1:0] K_LAST = KW'(RESP_BITS - 1);

    seq_state_t                    state_reg, state_next;
    logic [KW-1:0]                 k_reg, k_next;
    logic [RESP_BITS*2*SEL_W-1:0]  chal_reg, chal_next;
    logic                          timer_load, timer_zero;
    logic [TW-1:0]                 timer_value;
    logic [2*SEL_W-1:0]            pair_next;
    logic [SEL_W-1:0]              sel1_next, sel2_next;
    logic                          ro_enable_next, ro_reset_next, busy_next, done_next;
    logic                          degenerate, cnt_gt, cnt_eq, cnt_sat;

    puf_phase_timer #(.W(TW)) u_timer (
        .clk        (clock),
        .srst       (reset),
        .load       (timer_load),
        .load_value (timer_value),
        .zero       (timer_zero)
    );

    always_comb begin
        state_next = state_reg;
        k_next     = k_reg;
        chal_next  = chal_reg;
        case (state_reg)
            ST_IDLE: if (start) begin
                state_next = ST_CLEAR;
                k_next     = '0;
                chal_next  = challenge;
            end
            ST_CLEAR:  if (timer_zero) state_next = ST_RUN;
            ST_RUN:    if (timer_zero) state_next = ST_SETTLE;
            ST_SETTLE: if (timer_zero) state_next = ST_SAMPLE;
            ST_SAMPLE: begin
                if (k_reg == K_LAST) begin
                    state_next = ST_DONE;
                end else begin
                    state_next = ST_CLEAR;
                    k_next     = k_reg + KW'(1);
                end
            end
            ST_DONE:   state_next = ST_IDLE;
            default:   state_next = ST_IDLE;
        endcase
    end

    // Drive outputs are computed from the upcoming state so they register
    // in the same edge as the state itself.
    always_comb begin
        pair_next      = pair_slice(CH_MAX_W'(chal_next), 32'(k_next));
        sel1_next      = ro_select1;
        sel2_next      = ro_select2;
        if (state_next == ST_IDLE) begin
            sel1_next = '0;
            sel2_next = '0;
        end else if (state_next == ST_CLEAR && state_reg != ST_CLEAR) begin
            sel1_next = pair_next[SEL_W-1:0];
            sel2_next = pair_next[2*SEL_W-1:SEL_W];
        end
        ro_reset_next  = (state_next == ST_CLEAR);
        ro_enable_next = (state_next == ST_RUN);
        busy_next      = (state_next != ST_IDLE);
        done_next      = (state_next == ST_DONE);
        timer_load     = (state_next != state_reg);
        case (state_next)
            ST_CLEAR:  timer_value = TW'(CLR_CYC - 1);
            ST_RUN:    timer_value = TW'(WINDOW - 1);
            ST_SETTLE: timer_value = TW'(SETTLE - 1);
            default:   timer_value = '0;
        endcase
    end

    // Out-of-range selects can only occur when N_RO < 2^SEL_W.
    assign degenerate = (ro_select1 == ro_select2)
                     || ({1'b0, ro_select1} >= (SEL_W+1)'(N_RO))
                     || ({1'b0, ro_select2} >= (SEL_W+1)'(N_RO));
    assign cnt_gt  = (cnt1 > cnt2);
    assign cnt_eq  = (cnt1 == cnt2);
    assign cnt_sat = (cnt1 == '1) || (cnt2 == '1);

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg  <= ST_IDLE;
            k_reg      <= '0;
            chal_reg   <= '0;
            ro_select1 <= '0;
            ro_select2 <= '0;
            ro_enable  <= 1'b0;
            ro_reset   <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            response   <= '0;
            tie_mask   <= '0;
            sat_mask   <= '0;
        end else begin
            state_reg  <= state_next;
            k_reg      <= k_next;
            chal_reg   <= chal_next;
            ro_select1 <= sel1_next;
            ro_select2 <= sel2_next;
            ro_enable  <= ro_enable_next;
            ro_reset   <= ro_reset_next;
            busy       <= busy_next;
            done       <= done_next;
            if (state_reg == ST_IDLE && start) begin
                response <= '0;
                tie_mask <= '0;
                sat_mask <= '0;
            end else if (state_reg == ST_SAMPLE) begin
                response[k_reg] <= !degenerate && cnt_gt;
                tie_mask[k_reg] <= degenerate || cnt_eq;
                sat_mask[k_reg] <= cnt_sat;
            end
        end
    end

endmodule

// File: tb/tb_puf_challenge_sequencer.sv
// Directed and randomized bench for the challenge sequencer with a small
// configuration (4 pairs, 16-cycle window) and a table-driven counter model.
module tb_puf_challenge_sequencer;
    import puf_pkg::*;

    localparam int RB  = 4;
    localparam int WIN = 16;
    localparam int CLR = 2;
    localparam int SET = 2;
    localparam int P   = CLR + WIN + SET + 1;
    localparam int RUN_LEN = RB * P + 1;

    logic                 clk, reset, start;
    logic [RB*2*SEL_W-1:0] challenge;
    logic [CNT_W-1:0]     cnt1, cnt2;
    logic [SEL_W-1:0]     ro_select1, ro_select2;
    logic                 ro_enable, ro_reset, busy, done;
    logic [RB-1:0]        response, tie_mask, sat_mask;

    puf_challenge_sequencer #(
        .RESP_BITS (RB),
        .WINDOW    (WIN),
        .CLR_CYC   (CLR),
        .SETTLE    (SET)
    ) dut (
        .clock      (clk),
        .reset      (reset),
        .start      (start),
        .challenge  (challenge),
        .cnt1       (cnt1),
        .cnt2       (cnt2),
        .ro_select1 (ro_select1),
        .ro_select2 (ro_select2),
        .ro_enable  (ro_enable),
        .ro_reset   (ro_reset),
        .busy       (busy),
        .done       (done),
        .response   (response),
        .tie_mask   (tie_mask),
        .sat_mask   (sat_mask)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    logic [CNT_W-1:0] c1_tab [RB];
    logic [CNT_W-1:0] c2_tab [RB];
    int pair_idx = -1;
    bit mon = 1'b0;
    int rst_len = 0;
    int en_len = 0;
    int done_cnt = 0;
    logic prev_rst = 1'b0;
    logic prev_en = 1'b0;
    logic [SEL_W-1:0] rec1 = '0;
    logic [SEL_W-1:0] rec2 = '0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Expected {sat, tie, resp} from the pair rules and the count tables.
    function automatic logic [3*RB-1:0] model(input logic [RB*8-1:0] ch);
        logic [RB-1:0] r, t, s;
        logic [3:0] s1, s2;
        bit deg;
        for (int k = 0; k < RB; k++) begin
            s1 = ch[8*k +: 4];
            s2 = ch[8*k+4 +: 4];
            deg = (s1 == s2) || (int'(s1) >= N_RO) || (int'(s2) >= N_RO);
            r[k] = !deg && (c1_tab[k] > c2_tab[k]);
            t[k] = deg || (c1_tab[k] == c2_tab[k]);
            s[k] = (c1_tab[k] == 12'hFFF) || (c2_tab[k] == 12'hFFF);
        end
        return {s, t, r};
    endfunction

    // One clock: sample after the edge, run the drive monitor, update counts.
    task automatic step();
        @(posedge clk);
        #1;
        if (done) done_cnt++;
        if (ro_reset && !prev_rst) begin
            pair_idx++;
            rec1 = ro_select1;
            rec2 = ro_select2;
        end
        if (mon) begin
            check("overlap", 32'(ro_reset && ro_enable), 0);
            if (ro_reset) rst_len++;
            else if (prev_rst) begin
                check("rst_len", rst_len, CLR);
                rst_len = 0;
            end
            if (ro_enable) en_len++;
            else if (prev_en) begin
                check("en_len", en_len, WIN);
                en_len = 0;
            end
            if (ro_reset || ro_enable) begin
                check("sel1_hold", 32'(ro_select1), 32'(rec1));
                check("sel2_hold", 32'(ro_select2), 32'(rec2));
            end
        end
        prev_rst = ro_reset;
        prev_en = ro_enable;
        if (pair_idx >= 0 && pair_idx < RB) begin
            cnt1 = c1_tab[pair_idx];
            cnt2 = c2_tab[pair_idx];
        end else begin
            cnt1 = '0;
            cnt2 = '0;
        end
    endtask

    task automatic start_run(input logic [31:0] ch);
        challenge = ch;
        pair_idx = -1;
        start = 1'b1;
        step();
        start = 1'b0;
        check("start_busy", 32'(busy), 1);
        check("start_ro_reset", 32'(ro_reset), 1);
        check("start_ro_enable", 32'(ro_enable), 0);
        check("start_sel1", 32'(ro_select1), 32'(ch[3:0]));
        check("start_sel2", 32'(ro_select2), 32'(ch[7:4]));
        check("start_resp_clr", 32'(response), 0);
        check("start_tie_clr", 32'(tie_mask), 0);
        check("start_sat_clr", 32'(sat_mask), 0);
    endtask

    task automatic finish_run(input logic [31:0] ch, input bit poke);
        int n;
        int d0;
        logic [3*RB-1:0] exp;
        n = 1;
        d0 = done_cnt;
        while (!done && n < 400) begin
            if (poke && n == 40) start = 1'b1;
            step();
            start = 1'b0;
            n++;
        end
        exp = model(ch);
        check("done_latency", n, RUN_LEN);
        check("done_once", done_cnt - d0, 1);
        check("response", 32'(response), 32'(exp[RB-1:0]));
        check("tie_mask", 32'(tie_mask), 32'(exp[2*RB-1:RB]));
        check("sat_mask", 32'(sat_mask), 32'(exp[3*RB-1:2*RB]));
    endtask

    task automatic random_tables(output logic [31:0] ch);
        logic [3:0] s1, s2;
        int r;
        ch = '0;
        for (int k = 0; k < RB; k++) begin
            s1 = 4'($urandom_range(0, 15));
            s2 = ($urandom_range(0, 4) == 0) ? s1 : 4'($urandom_range(0, 15));
            ch[8*k +: 8] = {s2, s1};
            r = int'($urandom_range(0, 3));
            c1_tab[k] = (r == 3) ? 12'hFFF : 12'($urandom);
            c2_tab[k] = (r == 0) ? c1_tab[k] : (r == 1) ? 12'hFFF : 12'($urandom);
        end
    endtask

    logic [31:0] ch;
    int n;
    int d0;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        challenge = '0;
        cnt1 = '0;
        cnt2 = '0;
        repeat (3) step();
        check("rst_sel1", 32'(ro_select1), 0);
        check("rst_sel2", 32'(ro_select2), 0);
        check("rst_enable", 32'(ro_enable), 0);
        check("rst_ro_reset", 32'(ro_reset), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_resp", 32'(response), 0);
        check("rst_tie", 32'(tie_mask), 0);
        check("rst_sat", 32'(sat_mask), 0);
        reset = 1'b0;
        step();
        mon = 1'b1;

        // Basic run
        c1_tab = '{12'd100, 12'd50, 12'd200, 12'd7};
        c2_tab = '{12'd90, 12'd60, 12'd199, 12'd8};
        ch = 32'h8765_4321;
        start_run(ch);
        finish_run(ch, 1'b0);
        check("basic_resp", 32'(response), 32'h5);
        step();
        check("busy_after_done", 32'(busy), 0);
        repeat (4) step();
        check("resp_hold", 32'(response), 32'h5);

        // Degenerate, tie and saturation, with start poked while busy
        c1_tab = '{12'd30, 12'd77, 12'hFFF, 12'd5};
        c2_tab = '{12'd10, 12'd77, 12'h800, 12'd9};
        ch = 32'h36F0_9244;
        start_run(ch);
        finish_run(ch, 1'b1);
        check("deg_resp", 32'(response), 32'h4);
        check("deg_tie", 32'(tie_mask), 32'h3);
        check("deg_sat", 32'(sat_mask), 32'h4);

        // start during the DONE cycle is ignored; held one more cycle it is taken
        random_tables(ch);
        challenge = ch;
        start = 1'b1;
        step();
        check("done_start_busy", 32'(busy), 0);
        check("done_start_done", 32'(done), 0);
        pair_idx = -1;
        step();
        start = 1'b0;
        check("restart_busy", 32'(busy), 1);
        check("restart_resp_clr", 32'(response), 0);
        check("restart_tie_clr", 32'(tie_mask), 0);
        check("restart_sat_clr", 32'(sat_mask), 0);
        finish_run(ch, 1'b0);
        step();

        // Randomized runs
        for (int i = 0; i < 4; i++) begin
            random_tables(ch);
            start_run(ch);
            finish_run(ch, 1'b0);
            repeat (2) step();
        end

        // Reset during RUN of pair 2
        random_tables(ch);
        start_run(ch);
        n = 0;
        while (!(pair_idx == 2 && ro_enable) && n < 300) begin
            step();
            n++;
        end
        check("reach_run2", 32'(pair_idx == 2 && ro_enable), 1);
        repeat (3) step();
        mon = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        check("midrst_enable", 32'(ro_enable), 0);
        check("midrst_ro_reset", 32'(ro_reset), 0);
        check("midrst_busy", 32'(busy), 0);
        check("midrst_done", 32'(done), 0);
        check("midrst_sel", 32'({ro_select2, ro_select1}), 0);
        check("midrst_masks", 32'({sat_mask, tie_mask, response}), 0);
        d0 = done_cnt;
        repeat (100) step();
        check("midrst_no_done", done_cnt - d0, 0);
        rst_len = 0;
        en_len = 0;
        mon = 1'b1;
        random_tables(ch);
        start_run(ch);
        finish_run(ch, 1'b0);
        step();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/puf_challenge_sequencer.md
# puf_challenge_sequencer

Automatic challenge/response driver for the 16-way ring-oscillator PUF array: it takes the place of the manual VIO control path. It walks a list of ring-oscillator pairs, drives the mux selects, the oscillator enable and the counter clear for each pair, and opens a fixed measurement window in `clock` cycles. After each window it compares the two ring-oscillator counts and packs the results into a response word with per-bit tie and saturation flags.

## Interface
- `N_RO`, 16: ring oscillators in the array; every select value is in 0..N_RO-1.
- `SEL_W`, 4: select width, equal to clog2(N_RO).
- `CNT_W`, 12: width of the ring-oscillator counters.
- `RESP_BITS`, 8: challenge pairs per response, which is also the response width.
- `WINDOW`, 4095: `clock` cycles that `ro_enable` stays high per pair.
- `CLR_CYC`, 2: `clock` cycles that `ro_reset` stays high before each window.
- `SETTLE`, 4: quiet `clock` cycles after the window, before the counts are sampled.

Ports:
- `clock` in 1: the single system clock.
- `reset` in 1: synchronous, active-high.
- `start` in 1: request to run one challenge; honoured only while idle.
- `challenge` in RESP_BITS\*2\*SEL_W: pair k occupies bits [2k·SEL_W +: 2·SEL_W]; the low SEL_W bits are sel1 and the high SEL_W bits are sel2.
- `cnt1` in CNT_W: count from the ring oscillator chosen by `ro_select1`.
- `cnt2` in CNT_W: count from the ring oscillator chosen by `ro_select2`.
- `ro_select1` out SEL_W: mux-1 select.
- `ro_select2` out SEL_W: mux-2 select.
- `ro_enable` out 1: enables the oscillators and their counters.
- `ro_reset` out 1: clears the oscillator counters.
- `busy` out 1: high from the cycle after `start` is accepted until `done`, inclusive.
- `done` out 1: one-cycle pulse when the response is complete.
- `response` out RESP_BITS: bit k = (cnt1 > cnt2) for pair k.
- `tie_mask` out RESP_BITS: bit k = 1 when pair k gave cnt1 == cnt2, or when sel1 == sel2.
- `sat_mask` out RESP_BITS: bit k = 1 when either count for pair k equals all-ones.

## Operation
- FSM states are IDLE, CLEAR, RUN, SETTLE, SAMPLE and DONE. A pair index `k` runs 0..RESP_BITS-1.
- **IDLE**
  - All drive outputs are 0.
  - When `start` is high, `challenge` is latched, `k` = 0, `response`/`tie_mask`/`sat_mask` are cleared, and the FSM goes to CLEAR.
- **CLEAR** (CLR_CYC cycles): `ro_select1`/`ro_select2` take pair k; `ro_reset` = 1 and `ro_enable` = 0. Next state is RUN.
- **RUN** (WINDOW cycles): `ro_enable` = 1 and `ro_reset` = 0; the selects are held. Next state is SETTLE.
- **SETTLE** (SETTLE cycles): `ro_enable` = 0. The counters are clocked by the oscillators and are asynchronous to `clock`, so they must be frozen before sampling. Next state is SAMPLE.
- **SAMPLE** (1 cycle)
  - Writes `response[k]`, `tie_mask[k]` and `sat_mask[k]` from `cnt1`/`cnt2`.
  - The comparison is unsigned on CNT_W bits.
  - A degenerate pair (sel1 == sel2) forces response[k] = 0 and tie_mask[k] = 1, regardless of the counts.
  - If k == RESP_BITS-1 the FSM goes to DONE; otherwise k increments and the FSM goes to CLEAR.
- **DONE** (1 cycle): `done` = 1, then IDLE.
- `response`, `tie_mask` and `sat_mask` hold their values until the next accepted `start` or `reset`.
- `start` is ignored in every state except IDLE, including the DONE cycle.
- Select values ≥ N_RO (only possible when N_RO < 2^SEL_W) are treated as degenerate.

## Timing
- Every output is registered.
- Reset values: all outputs are 0, the state is IDLE and k = 0.
- `reset` mid-operation: on the next edge the FSM is in IDLE and `ro_enable` = 0. The masks and response are cleared and `done` does not pulse.
- Per-pair period P = CLR_CYC + WINDOW + SETTLE + 1; the defaults give P = 4102.
- If `start` is sampled at edge t:
  - `busy` and `ro_reset` go high in cycle t+1.
  - `ro_enable` goes high in cycle t+1+CLR_CYC.
  - `done` is high in cycle t+1+RESP_BITS·P.
- The selects change only on entry to CLEAR and are stable for the whole pair period.
- `response[k]` is visible starting the cycle after SAMPLE.
- `busy` drops in the cycle after `done`.

## Structure
- **Shared package `puf_pkg`:** the state enum `seq_state_t`, the constants N_RO, SEL_W and CNT_W, and the `challenge` pair-slice helper function. The PUF top-level reuses these.
- **Sub-module `puf_phase_timer`:**
  - Down-counter with load and a `zero` flag.
  - Width is clog2(max(WINDOW, CLR_CYC, SETTLE)+1).
  - It is loaded with the length of each phase on state entry.
- The FSM, pair indexing and result registers live in `puf_challenge_sequencer`.

## Test plan
Parameters: WINDOW = 16, CLR_CYC = 2, SETTLE = 2, RESP_BITS = 4, giving P = 21.

1. **Basic run.** challenge = pairs (1,2), (3,4), (5,6), (7,8); the counter model returns cnt1 = 100/cnt2 = 90, then 50/60, 200/199, 7/8. Required: response = 4'b0101, tie_mask = 0, sat_mask = 0, and `done` exactly 85 cycles after `start`.
2. **Drive timing.** Check `ro_reset` is high for exactly 2 cycles and `ro_enable` for exactly 16 cycles per pair. `ro_enable` and `ro_reset` are never high together, and the selects are stable across each 21-cycle period.
3. **Degenerate and tie.**
   - Pair 0 = (4,4) with counts 30/10 gives response[0] = 0 and tie_mask[0] = 1.
   - Pair 1 = (2,9) with counts 77/77 gives tie_mask[1] = 1 and response[1] = 0.
4. **Saturation.** cnt1 = 12'hFFF and cnt2 = 12'h800 on pair 2 give sat_mask[2] = 1 and response[2] = 1.
5. **Start handling.** Pulse `start` while `busy` and during the `done` cycle: neither is accepted and `done` does not pulse again. A `start` one cycle after `done` is accepted and the masks are cleared.
6. **Reset mid-run.** Assert `reset` during RUN of pair 2. One cycle later all outputs are 0; no `done` appears; a following `start` produces a full, correct 85-cycle run.
